// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding receive checker for the LFSR pattern stream.
// Locks after LOCK_COUNT successor matches, then flywheels and tracks word, error and bit-error counts.
module lfsr_checker #(
    parameter int OUT_WIDTH  = 128,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr_cnt,
    input  logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] bit_err_cnt
);
    localparam int PCW = $clog2(OUT_WIDTH + 1);
    localparam int SW  = (CNT_WIDTH > PCW ? CNT_WIDTH : PCW) + 1;
    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int XW  = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t               st, st_n;
    logic [OUT_WIDTH-1:0] ref_q, ref_n, pred;
    logic [MW-1:0]        match_run, mrun_n;
    logic [XW-1:0]        miss_run, xrun_n;
    logic [CNT_WIDTH-1:0] wc_n, ec_n, bc_n;
    logic [PCW-1:0]       pc;
    logic [SW-1:0]        bsum;
    logic                 nz, match, pulse_n;

    assign pred   = {ref_q[OUT_WIDTH-2:0], ref_q[10] ^ ref_q[12] ^ ref_q[13] ^ ref_q[15] ^ ref_q[OUT_WIDTH-1]};
    assign nz     = |in_data;
    assign match  = in_data == pred;
    assign pc     = PCW'($countones(in_data ^ pred));
    assign bsum   = SW'(bit_err_cnt) + SW'(pc);
    assign locked = st == LOCKED;

    always_comb begin
        st_n    = st;
        ref_n   = ref_q;
        mrun_n  = match_run;
        xrun_n  = miss_run;
        wc_n    = word_cnt;
        ec_n    = err_cnt;
        bc_n    = bit_err_cnt;
        pulse_n = 1'b0;
        if (in_valid) begin
            case (st)
                SEARCH: begin
                    if (nz) begin
                        ref_n  = in_data;
                        mrun_n = '0;
                        st_n   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (nz && match) begin
                        ref_n  = in_data;
                        mrun_n = match_run + 1'b1;
                        if (mrun_n == MW'(LOCK_COUNT)) begin
                            st_n   = LOCKED;
                            xrun_n = '0;
                        end
                    end else if (nz) begin
                        ref_n  = in_data;
                        mrun_n = '0;
                    end else begin
                        st_n = SEARCH;
                    end
                end
                LOCKED: begin
                    // flywheel: the prediction advances regardless of what arrived
                    ref_n = pred;
                    wc_n  = (&word_cnt) ? word_cnt : word_cnt + 1'b1;
                    if (match) begin
                        xrun_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        ec_n    = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
                        bc_n    = (bsum > SW'({CNT_WIDTH{1'b1}})) ? '1 : bsum[CNT_WIDTH-1:0];
                        xrun_n  = miss_run + 1'b1;
                        if (xrun_n == XW'(LOSS_COUNT)) begin
                            st_n   = nz ? VERIFY : SEARCH;
                            ref_n  = in_data;
                            mrun_n = '0;
                        end
                    end
                end
                default: st_n = SEARCH;
            endcase
        end
        if (clr_cnt) begin
            wc_n = '0;
            ec_n = '0;
            bc_n = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st          <= SEARCH;
            ref_q       <= '0;
            match_run   <= '0;
            miss_run    <= '0;
            err_pulse   <= 1'b0;
            word_cnt    <= '0;
            err_cnt     <= '0;
            bit_err_cnt <= '0;
        end else begin
            st          <= st_n;
            ref_q       <= ref_n;
            match_run   <= mrun_n;
            miss_run    <= xrun_n;
            err_pulse   <= pulse_n;
            word_cnt    <= wc_n;
            err_cnt     <= ec_n;
            bit_err_cnt <= bc_n;
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lock, flywheel, loss, gaps, zero link and counter saturation.
module tb_lfsr_checker;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         clr_cnt = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         locked, err_pulse, locked4, err_pulse4;
    logic [31:0]  word_cnt, err_cnt, bit_err_cnt;
    logic [3:0]   word_cnt4, err_cnt4, bit_err_cnt4;
    logic [127:0] g;
    int           ncmp = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .resetn(resetn), .clr_cnt(clr_cnt), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .word_cnt(word_cnt), .err_cnt(err_cnt), .bit_err_cnt(bit_err_cnt)
    );

    lfsr_checker #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .clr_cnt(clr_cnt), .in_valid(in_valid), .in_data(in_data),
        .locked(locked4), .err_pulse(err_pulse4), .word_cnt(word_cnt4), .err_cnt(err_cnt4), .bit_err_cnt(bit_err_cnt4)
    );

    function automatic logic [127:0] nxt(input logic [127:0] w);
        return {w[126:0], w[10] ^ w[12] ^ w[13] ^ w[15] ^ w[127]};
    endfunction

    task automatic send(input logic [127:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        in_data  = '0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++; if (locked !== 1'b0) begin nerr++; $display("FAIL reset_locked: got %0h want 0", locked); end
        ncmp++; if (err_pulse !== 1'b0) begin nerr++; $display("FAIL reset_pulse: got %0h want 0", err_pulse); end
        ncmp++; if (word_cnt !== 32'd0) begin nerr++; $display("FAIL reset_word: got %0d want 0", word_cnt); end
        ncmp++; if (err_cnt !== 32'd0) begin nerr++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        ncmp++; if (bit_err_cnt !== 32'd0) begin nerr++; $display("FAIL reset_bit: got %0d want 0", bit_err_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        g = 128'hACE1;
        for (int i = 1; i <= 1000; i++) begin
            send(g);
            g = nxt(g);
            if (i == 4) begin ncmp++; if (locked !== 1'b0) begin nerr++; $display("FAIL lock_early: got %0h want 0", locked); end end
            if (i == 5) begin ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL lock_5th: got %0h want 1", locked); end end
        end
        ncmp++; if (word_cnt !== 32'd995) begin nerr++; $display("FAIL lock_word: got %0d want 995", word_cnt); end
        ncmp++; if (err_cnt !== 32'd0) begin nerr++; $display("FAIL lock_err: got %0d want 0", err_cnt); end
        ncmp++; if (bit_err_cnt !== 32'd0) begin nerr++; $display("FAIL lock_bit: got %0d want 0", bit_err_cnt); end
    endtask

    task automatic test_single_err();
        send(g ^ 128'h1);
        g = nxt(g);
        ncmp++; if (err_pulse !== 1'b1) begin nerr++; $display("FAIL single_pulse: got %0h want 1", err_pulse); end
        ncmp++; if (err_cnt !== 32'd1) begin nerr++; $display("FAIL single_err: got %0d want 1", err_cnt); end
        ncmp++; if (bit_err_cnt !== 32'd1) begin nerr++; $display("FAIL single_bit: got %0d want 1", bit_err_cnt); end
        ncmp++; if (word_cnt !== 32'd996) begin nerr++; $display("FAIL single_word: got %0d want 996", word_cnt); end
        send(g);
        g = nxt(g);
        ncmp++; if (err_pulse !== 1'b0) begin nerr++; $display("FAIL single_pulse_fall: got %0h want 0", err_pulse); end
        ncmp++; if (err_cnt !== 32'd1) begin nerr++; $display("FAIL single_recover: got %0d want 1", err_cnt); end
        ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL single_locked: got %0h want 1", locked); end
    endtask

    task automatic test_loss();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        ncmp++; if (word_cnt !== 32'd0) begin nerr++; $display("FAIL clr_word: got %0d want 0", word_cnt); end
        ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL clr_state: got %0h want 1", locked); end
        for (int k = 1; k <= 4; k++) begin
            send(g ^ 128'h0700);
            g = nxt(g);
            if (k == 3) begin ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL loss_3rd: got %0h want 1", locked); end end
        end
        ncmp++; if (locked !== 1'b0) begin nerr++; $display("FAIL loss_4th: got %0h want 0", locked); end
        ncmp++; if (err_cnt !== 32'd4) begin nerr++; $display("FAIL loss_err: got %0d want 4", err_cnt); end
        ncmp++; if (bit_err_cnt !== 32'd12) begin nerr++; $display("FAIL loss_bit: got %0d want 12", bit_err_cnt); end
        for (int k = 1; k <= 5; k++) begin
            send(g);
            g = nxt(g);
            if (k == 4) begin ncmp++; if (locked !== 1'b0) begin nerr++; $display("FAIL relock_early: got %0h want 0", locked); end end
        end
        ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL relock: got %0h want 1", locked); end
        ncmp++; if (word_cnt !== 32'd4) begin nerr++; $display("FAIL relock_word: got %0d want 4", word_cnt); end
    endtask

    task automatic test_gaps();
        int n = 0;
        int cyc = 0;
        int pulses = 0;
        do_reset();
        g = 128'hACE1;
        while (n < 1000 && cyc < 10000) begin
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid) in_data = g;
            @(posedge clk);
            #1;
            if (in_valid) begin g = nxt(g); n++; end
            if (err_pulse) pulses++;
            cyc++;
        end
        in_valid = 1'b0;
        ncmp++; if (n !== 1000) begin nerr++; $display("FAIL gaps_budget: got %0d words want 1000", n); end
        ncmp++; if (word_cnt !== 32'd995) begin nerr++; $display("FAIL gaps_word: got %0d want 995", word_cnt); end
        ncmp++; if (err_cnt !== 32'd0) begin nerr++; $display("FAIL gaps_err: got %0d want 0", err_cnt); end
        ncmp++; if (pulses !== 0) begin nerr++; $display("FAIL gaps_pulse: got %0d want 0", pulses); end
        ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL gaps_locked: got %0h want 1", locked); end
    endtask

    task automatic test_zero();
        do_reset();
        for (int i = 0; i < 100; i++) send('0);
        ncmp++; if (locked !== 1'b0) begin nerr++; $display("FAIL zero_locked: got %0h want 0", locked); end
        ncmp++; if ({word_cnt, err_cnt, bit_err_cnt} !== 96'd0) begin nerr++; $display("FAIL zero_cnts: got %0h want 0", {word_cnt, err_cnt, bit_err_cnt}); end
        g = 128'hACE1;
        for (int i = 0; i < 8; i++) begin send(g); g = nxt(g); end
        ncmp++; if (locked !== 1'b1) begin nerr++; $display("FAIL zero_relock: got %0h want 1", locked); end
        ncmp++; if (word_cnt !== 32'd3) begin nerr++; $display("FAIL zero_word: got %0d want 3", word_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        g = 128'hACE1;
        for (int i = 0; i < 5; i++) begin send(g); g = nxt(g); end
        for (int i = 0; i < 20; i++) begin
            send(g ^ 128'h1); g = nxt(g);
            send(g); g = nxt(g);
        end
        ncmp++; if (err_cnt4 !== 4'd15) begin nerr++; $display("FAIL sat_err: got %0d want 15", err_cnt4); end
        ncmp++; if (bit_err_cnt4 !== 4'd15) begin nerr++; $display("FAIL sat_bit: got %0d want 15", bit_err_cnt4); end
        ncmp++; if (word_cnt4 !== 4'd15) begin nerr++; $display("FAIL sat_word: got %0d want 15", word_cnt4); end
        ncmp++; if (err_cnt !== 32'd20) begin nerr++; $display("FAIL wide_err: got %0d want 20", err_cnt); end
        clr_cnt = 1'b1;
        send(g ^ 128'h1);
        clr_cnt = 1'b0;
        g = nxt(g);
        ncmp++; if (err_cnt4 !== 4'd0) begin nerr++; $display("FAIL clr_wins_err: got %0d want 0", err_cnt4); end
        ncmp++; if (bit_err_cnt4 !== 4'd0) begin nerr++; $display("FAIL clr_wins_bit: got %0d want 0", bit_err_cnt4); end
        ncmp++; if (err_pulse4 !== 1'b1) begin nerr++; $display("FAIL clr_pulse: got %0h want 1", err_pulse4); end
        send(g ^ 128'h2);
        g = nxt(g);
        ncmp++; if (err_cnt4 !== 4'd1) begin nerr++; $display("FAIL post_clr_err: got %0d want 1", err_cnt4); end
        ncmp++; if (locked4 !== 1'b1) begin nerr++; $display("FAIL pre_rst_locked: got %0h want 1", locked4); end
        resetn = 1'b0;
        #1;
        ncmp++; if (locked4 !== 1'b0) begin nerr++; $display("FAIL async_locked: got %0h want 0", locked4); end
        ncmp++; if (err_pulse4 !== 1'b0) begin nerr++; $display("FAIL async_pulse: got %0h want 0", err_pulse4); end
        ncmp++; if ({word_cnt4, err_cnt4, bit_err_cnt4} !== 12'd0) begin nerr++; $display("FAIL async_cnts: got %0h want 0", {word_cnt4, err_cnt4, bit_err_cnt4}); end
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_loss();
        test_gaps();
        test_zero();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
